beep_sequencer: RTL and testbench



---
 rtl/beep_sequencer.sv | 167 ++++++++++++++++
 tb/tb_beep_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/beep_sequencer.sv
// beep_sequencer: turns a one-cycle trigger pulse into a timed buzzer pattern.
// A trigger starts beep_cnt tone bursts (ON_CYC cycles each) separated by
// silent gaps (OFF_CYC cycles). During a burst the buzzer pin carries a square
// wave with a half-period of TONE_HALF cycles. A stop pulse aborts at once.
// All outputs are registered. Reset rst is asynchronous and active-low.
module beep_sequencer #(
  parameter int unsigned TONE_HALF = 25000,
  parameter int unsigned ON_CYC    = 5000000,
  parameter int unsigned OFF_CYC   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [2:0] beep_cnt,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int unsigned TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int unsigned ON_W   = (ON_CYC    > 1) ? $clog2(ON_CYC)    : 1;
  localparam int unsigned OFF_W  = (OFF_CYC   > 1) ? $clog2(OFF_CYC)   : 1;

  // Terminal values of each counter.
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(ON_CYC - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(OFF_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  state_t              state_q,     state_d;
  logic [2:0]          remaining_q, remaining_d;
  logic [TONE_W-1:0]   tone_cnt_q,  tone_cnt_d;
  logic [ON_W-1:0]     on_cnt_q,    on_cnt_d;
  logic [OFF_W-1:0]    off_cnt_q,   off_cnt_d;
  logic                buzzer_q,    buzzer_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      tone_cnt_q  <= '0;
      on_cnt_q    <= '0;
      off_cnt_q   <= '0;
      buzzer_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tone_cnt_q  <= tone_cnt_d;
      on_cnt_q    <= on_cnt_d;
      off_cnt_q   <= off_cnt_d;
      buzzer_q    <= buzzer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counter and registered-output logic.
  // Outputs are computed for the *next* cycle, so each transition also sets
  // the buzzer/busy/done values seen in the first cycle of the new state.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tone_cnt_d  = tone_cnt_q;
    on_cnt_d    = on_cnt_q;
    off_cnt_d   = off_cnt_q;
    buzzer_d    = buzzer_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (stop) begin
      // Abort wins over everything, including a simultaneous trigger.
      state_d     = IDLE;
      remaining_d = '0;
      tone_cnt_d  = '0;
      on_cnt_d    = '0;
      off_cnt_d   = '0;
      buzzer_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          buzzer_d = 1'b0;
          busy_d   = 1'b0;
          if (trig && (beep_cnt != 3'd0)) begin
            state_d     = ON;
            remaining_d = beep_cnt;
            tone_cnt_d  = '0;
            on_cnt_d    = '0;
            off_cnt_d   = '0;
            buzzer_d    = 1'b1;
            busy_d      = 1'b1;
          end
        end

        ON: begin
          busy_d = 1'b1;
          if (on_cnt_q == ON_LAST) begin
            // Burst over: buzzer forced low even if mid half-period.
            on_cnt_d   = '0;
            tone_cnt_d = '0;
            buzzer_d   = 1'b0;
            if (remaining_q > 3'd1) begin
              remaining_d = remaining_q - 3'd1;
              off_cnt_d   = '0;
              state_d     = OFF;
            end else begin
              remaining_d = '0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = IDLE;
            end
          end else begin
            on_cnt_d = on_cnt_q + ON_W'(1);
            if (tone_cnt_q == TONE_LAST) begin
              tone_cnt_d = '0;
              buzzer_d   = ~buzzer_q;
            end else begin
              tone_cnt_d = tone_cnt_q + TONE_W'(1);
            end
          end
        end

        OFF: begin
          buzzer_d = 1'b0;
          busy_d   = 1'b1;
          if (off_cnt_q == OFF_LAST) begin
            // Next burst starts high with a fresh tone phase.
            off_cnt_d  = '0;
            on_cnt_d   = '0;
            tone_cnt_d = '0;
            buzzer_d   = 1'b1;
            state_d    = ON;
          end else begin
            off_cnt_d = off_cnt_q + OFF_W'(1);
          end
        end

        default: begin
          state_d     = IDLE;
          remaining_d = '0;
          tone_cnt_d  = '0;
          on_cnt_d    = '0;
          off_cnt_d   = '0;
          buzzer_d    = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  assign buzzer = buzzer_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer. Stimulus pushes per-cycle expected
// {buzzer,busy,done} traces into a queue; a monitor pops and compares one
// entry per clock on the falling edge.
module tb_beep_sequencer;

  logic       clk;
  logic       rst;
  logic       trig1, stop1;
  logic [2:0] cnt1;
  logic       buzzer1, busy1, done1;
  logic       trig2, stop2;
  logic [2:0] cnt2;
  logic       buzzer2, busy2, done2;

  typedef struct {
    logic [2:0]  exp;
    string       name;
    int unsigned idx;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m_e;

  int unsigned checks = 0;
  int unsigned errors = 0;

  beep_sequencer #(.TONE_HALF(2), .ON_CYC(8), .OFF_CYC(4)) dut1 (
    .clk(clk), .rst(rst), .trig(trig1), .beep_cnt(cnt1), .stop(stop1),
    .buzzer(buzzer1), .busy(busy1), .done(done1)
  );

  beep_sequencer #(.TONE_HALF(2), .ON_CYC(7), .OFF_CYC(4)) dut2 (
    .clk(clk), .rst(rst), .trig(trig2), .beep_cnt(cnt2), .stop(stop2),
    .buzzer(buzzer2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one comparison per queued entry per falling edge.
  always @(negedge clk) begin
    if (q1.size() != 0) begin
      m_e = q1.pop_front();
      checks++;
      if ({buzzer1, busy1, done1} !== m_e.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: buzzer/busy/done got %b required %b",
                 m_e.name, m_e.idx, {buzzer1, busy1, done1}, m_e.exp);
      end
    end
    if (q2.size() != 0) begin
      m_e = q2.pop_front();
      checks++;
      if ({buzzer2, busy2, done2} !== m_e.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: buzzer/busy/done got %b required %b",
                 m_e.name, m_e.idx, {buzzer2, busy2, done2}, m_e.exp);
      end
    end
  end

  task automatic push_trace(input int unsigned which, input string name,
                            input string bz, input string bs, input string dn);
    exp_t e;
    if (bz.len() != bs.len() || bz.len() != dn.len()) begin
      $display("FAIL %s: trace length bz=%0d bs=%0d dn=%0d", name, bz.len(), bs.len(), dn.len());
      $fatal(1);
    end
    for (int i = 0; i < bz.len(); i++) begin
      e.exp  = {bz.getc(i) == 8'd49, bs.getc(i) == 8'd49, dn.getc(i) == 8'd49};
      e.name = name;
      e.idx  = i;
      if (which == 1) q1.push_back(e);
      else            q2.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400; n++) begin
      if (q1.size() == 0 && q2.size() == 0) return;
      @(posedge clk);
      #1;
    end
    $display("FAIL drain: queues not emptied, got q1=%0d q2=%0d required 0", q1.size(), q2.size());
    $fatal(1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    string p8, h8, z8, p7, h7, z7, z4, o4;
    string bz, bs, dn;
    p8 = "11001100"; h8 = "11111111"; z8 = "00000000";
    p7 = "1100110";  h7 = "1111111";  z7 = "0000000";
    z4 = "0000";     o4 = "1111";

    rst = 1'b0;
    trig1 = 1'b0; stop1 = 1'b0; cnt1 = 3'd0;
    trig2 = 1'b0; stop2 = 1'b0; cnt2 = 3'd0;

    // Reset state, checked while reset is held.
    push_trace(1, "reset_state", "00", "00", "00");
    wait_drain();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(2);

    // Single burst.
    trig1 = 1'b1; cnt1 = 3'd1;
    push_trace(1, "single", {"0", p8, "00"}, {"0", h8, "00"}, {"0", z8, "10"});
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    wait_drain();
    cyc(2);

    // Two bursts, with a retrigger at cycle 10 that must be ignored.
    trig1 = 1'b1; cnt1 = 3'd2;
    push_trace(1, "two_retrig", {"0", p8, z4, p8, "00"}, {"0", h8, o4, h8, "00"},
               {"0", z8, z4, z8, "10"});
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    cyc(9); trig1 = 1'b1; cnt1 = 3'd5;
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    wait_drain();
    cyc(2);

    // Zero count: no action.
    trig1 = 1'b1; cnt1 = 3'd0;
    push_trace(1, "zero_cnt", "000000", "000000", "000000");
    cyc(1); trig1 = 1'b0;
    wait_drain();
    cyc(2);

    // Abort during the gap after the first burst (stop at cycle 11).
    trig1 = 1'b1; cnt1 = 3'd3;
    push_trace(1, "abort", {"0", p8, "000", "00000"}, {"0", h8, "111", "00000"},
               {"0", z8, "000", "00000"});
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    cyc(10); stop1 = 1'b1;
    cyc(1); stop1 = 1'b0;
    wait_drain();
    cyc(2);

    // Stop together with trigger in idle: stays idle.
    trig1 = 1'b1; stop1 = 1'b1; cnt1 = 3'd3;
    push_trace(1, "stop_trig", z8, z8, z8);
    cyc(1); trig1 = 1'b0; stop1 = 1'b0; cnt1 = 3'd0;
    wait_drain();
    cyc(2);

    // Asynchronous reset mid-burst at cycle 5, released at cycle 7.
    trig1 = 1'b1; cnt1 = 3'd1;
    push_trace(1, "reset_mid", "01100000000", "01111000000", "00000000000");
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    cyc(4); rst = 1'b0;
    cyc(2); rst = 1'b1;
    wait_drain();
    cyc(2);

    // Recovery after reset: a normal single burst again.
    trig1 = 1'b1; cnt1 = 3'd1;
    push_trace(1, "after_reset", {"0", p8, "00"}, {"0", h8, "00"}, {"0", z8, "10"});
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    wait_drain();
    cyc(2);

    // Odd burst length (ON_CYC=7) on the second instance, two bursts.
    trig2 = 1'b1; cnt2 = 3'd2;
    push_trace(2, "odd_on7", {"0", p7, z4, p7, "00"}, {"0", h7, o4, h7, "00"},
               {"0", z7, z4, z7, "10"});
    cyc(1); trig2 = 1'b0; cnt2 = 3'd0;
    wait_drain();
    cyc(2);

    // Maximum count: seven bursts.
    bz = "0"; bs = "0"; dn = "0";
    for (int b = 0; b < 7; b++) begin
      bz = {bz, p8}; bs = {bs, h8}; dn = {dn, z8};
      if (b < 6) begin
        bz = {bz, z4}; bs = {bs, o4}; dn = {dn, z4};
      end
    end
    bz = {bz, "00"}; bs = {bs, "00"}; dn = {dn, "10"};
    trig1 = 1'b1; cnt1 = 3'd7;
    push_trace(1, "seven", bz, bs, dn);
    cyc(1); trig1 = 1'b0; cnt1 = 3'd0;
    wait_drain();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
